// File: rtl/rate_tick_counter_pkg.sv
// Shared types and helpers for the programmable-rate tick counter.
package rate_tick_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  // Clocks per tick for a given speed; only ever evaluated at elaboration.
  function automatic int unsigned period_for(input int unsigned base,
                                             input int unsigned speed,
                                             input logic        slow);
    int unsigned p;
    if (speed == 32'd0) begin
      p = base;
    end else if (slow) begin
      p = base * speed;
    end else begin
      p = base / speed;
    end
    if (p == 32'd0) begin
      p = 32'd1;
    end else begin
      p = p;
    end
    return p;
  endfunction

endpackage

// File: rtl/rate_tick_counter_if.sv
// Control/status bundle of rate_tick_counter. With COUNT_DOWN_EN defined the
// bundle carries the extra i_dir direction input.
interface rate_tick_counter_if #(
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned MAX_SPEED = 8
);
  localparam int unsigned SPD_W = $clog2(MAX_SPEED + 1);

  logic             i_start;
  logic             i_pause;
  logic             i_stop;
  logic             i_speed_up;
  logic             i_speed_dn;
  logic             i_slow;
`ifdef COUNT_DOWN_EN
  logic             i_dir;
`endif
  logic [CNT_W-1:0] o_count;
  logic             o_tick;
  logic             o_wrap;
  logic [SPD_W-1:0] o_speed;
  logic [1:0]       o_state;

  modport master (
    output i_start, i_pause, i_stop, i_speed_up, i_speed_dn, i_slow,
`ifdef COUNT_DOWN_EN
    output i_dir,
`endif
    input  o_count, o_tick, o_wrap, o_speed, o_state
  );

  modport slave (
    input  i_start, i_pause, i_stop, i_speed_up, i_speed_dn, i_slow,
`ifdef COUNT_DOWN_EN
    input  i_dir,
`endif
    output o_count, o_tick, o_wrap, o_speed, o_state
  );

endinterface

// File: rtl/rate_tick_counter_divider.sv
// Period divider: constant period table, restart on speed/mode change and
// expiry strobe. A config change is seen one cycle after it lands and clears
// the divider without a tick, so a shorter period can never be overshot.
module rate_divider
  import rate_tick_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = 100000,
  parameter int unsigned MAX_SPEED   = 8,
  localparam int unsigned SPD_W      = $clog2(MAX_SPEED + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [SPD_W-1:0] speed_i,
  input  logic             slow_i,
  input  logic             run_i,
  input  logic             clr_i,
  output logic             expire_o
);

  localparam int unsigned DIV_W = $clog2(BASE_PERIOD * MAX_SPEED + 1);

  logic [DIV_W-1:0] fast_last_s [MAX_SPEED+1];
  logic [DIV_W-1:0] slow_last_s [MAX_SPEED+1];

  for (genvar s = 0; s <= MAX_SPEED; s++) begin : g_tbl
    assign fast_last_s[s] = DIV_W'(period_for(BASE_PERIOD, s, 1'b0) - 32'd1);
    assign slow_last_s[s] = DIV_W'(period_for(BASE_PERIOD, s, 1'b1) - 32'd1);
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic [SPD_W-1:0] speed_prev_q;
  logic             slow_q, slow_prev_q;
  logic [DIV_W-1:0] last_s;
  logic             cfg_chg_s, at_last_s, expire_s;

  always_comb begin
    cfg_chg_s = (speed_i != speed_prev_q) || (slow_q != slow_prev_q);
    last_s    = slow_q ? slow_last_s[speed_i] : fast_last_s[speed_i];
    at_last_s = (div_q == last_s);
    expire_s  = run_i && !cfg_chg_s && at_last_s;
    div_d     = div_q;
    if (clr_i || cfg_chg_s) begin
      div_d = {DIV_W{1'b0}};
    end else if (run_i) begin
      if (at_last_s) begin
        div_d = {DIV_W{1'b0}};
      end else begin
        div_d = div_q + DIV_W'(1'b1);
      end
    end else begin
      div_d = div_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_q        <= {DIV_W{1'b0}};
      speed_prev_q <= SPD_W'(1'b1);
      slow_q       <= 1'b0;
      slow_prev_q  <= 1'b0;
    end else begin
      div_q        <= div_d;
      speed_prev_q <= speed_i;
      slow_q       <= slow_i;
      slow_prev_q  <= slow_q;
    end
  end

  assign expire_o = expire_s;

endmodule

// File: rtl/rate_tick_counter.sv
// Programmable-rate tick counter: run/pause/stop FSM, saturating speed
// register and tick counter. COUNT_DOWN_EN adds down-counting via i_dir.
module rate_tick_counter
  import rate_tick_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = 100000,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned MAX_SPEED   = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  rate_tick_counter_if.slave  ctl
);

  localparam int unsigned       SPD_W   = $clog2(MAX_SPEED + 1);
  localparam logic [SPD_W-1:0]  SPD_MIN = SPD_W'(1);
  localparam logic [SPD_W-1:0]  SPD_MAX = SPD_W'(MAX_SPEED);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q;
  logic [SPD_W-1:0] speed_q, speed_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             run_s, expire_s, dir_s;

  // Divider only advances while RUN is kept; pause/stop freeze or clear it.
  assign run_s = (state_q == ST_RUN) && !ctl.i_stop && !ctl.i_pause;

`ifdef COUNT_DOWN_EN
  assign dir_s = ctl.i_dir;
`else
  assign dir_s = 1'b0;
`endif

  rate_divider #(
    .BASE_PERIOD (BASE_PERIOD),
    .MAX_SPEED   (MAX_SPEED)
  ) u_div (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .speed_i  (speed_q),
    .slow_i   (ctl.i_slow),
    .run_i    (run_s),
    .clr_i    (ctl.i_stop),
    .expire_o (expire_s)
  );

  always_comb begin
    speed_d = speed_q;
    if (ctl.i_speed_up && !ctl.i_speed_dn) begin
      if (speed_q != SPD_MAX) begin
        speed_d = speed_q + SPD_W'(1'b1);
      end else begin
        speed_d = speed_q;
      end
    end else if (ctl.i_speed_dn && !ctl.i_speed_up) begin
      if (speed_q != SPD_MIN) begin
        speed_d = speed_q - SPD_W'(1'b1);
      end else begin
        speed_d = speed_q;
      end
    end else begin
      speed_d = speed_q;
    end
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    tick_d  = expire_s;
    if (ctl.i_stop) begin
      count_d = {CNT_W{1'b0}};
    end else if (expire_s) begin
      if (dir_s) begin
        count_d = count_q - CNT_W'(1'b1);
        wrap_d  = (count_q == {CNT_W{1'b0}});
      end else begin
        count_d = count_q + CNT_W'(1'b1);
        wrap_d  = (count_q == CNT_MAX);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Command priority is stop > pause > start, also outside RUN.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!ctl.i_stop && !ctl.i_pause && ctl.i_start) state_q <= ST_RUN;
          else                                             state_q <= ST_IDLE;
        end
        ST_RUN: begin
          if (ctl.i_stop)       state_q <= ST_IDLE;
          else if (ctl.i_pause) state_q <= ST_PAUSE;
          else                  state_q <= ST_RUN;
        end
        ST_PAUSE: begin
          if (ctl.i_stop)                          state_q <= ST_IDLE;
          else if (!ctl.i_pause && ctl.i_start)    state_q <= ST_RUN;
          else                                     state_q <= ST_PAUSE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      speed_q <= SPD_MIN;
      count_q <= {CNT_W{1'b0}};
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      speed_q <= speed_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign ctl.o_count = count_q;
  assign ctl.o_tick  = tick_q;
  assign ctl.o_wrap  = wrap_q;
  assign ctl.o_speed = speed_q;
  assign ctl.o_state = state_q;

endmodule

// File: tb/tb_rate_tick_counter.sv
// Self-checking bench for rate_tick_counter (BASE_PERIOD=8, CNT_W=4, MAX_SPEED=8).
module tb_rate_tick_counter;

  localparam int BP   = 8;
  localparam int CW   = 4;
  localparam int MS   = 8;
  localparam int CMAX = (1 << CW) - 1;
`ifdef COUNT_DOWN_EN
  localparam bit DIR_EN = 1'b1;
`else
  localparam bit DIR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rate_tick_counter_if #(.CNT_W(CW), .MAX_SPEED(MS)) intf();

  rate_tick_counter #(
    .BASE_PERIOD (BP),
    .CNT_W       (CW),
    .MAX_SPEED   (MS)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .ctl   (intf)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit cur_slow = 1'b0;
  bit cur_dir  = 1'b0;
  int tq[$];
  int qc[$];

  // reference state
  int m_state, m_speed, m_age, m_count;
  bit m_slow, m_pending, m_tick, m_wrap;

  typedef struct {
    bit st, pa, sp, up, dn;
    int exp_state, exp_speed;
  } vec_t;
  vec_t vt[14];

  function automatic int period_of(int spd, bit slw);
    int q;
    if (slw) return BP * spd;
    q = BP / spd;
    return (q < 1) ? 1 : q;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_speed = 1; m_age = 0; m_count = 0;
    m_slow = 1'b0; m_pending = 1'b0; m_tick = 1'b0; m_wrap = 1'b0;
  endtask

  task automatic model_edge(input bit st, pa, sp, up, dn, sl, dr);
    int n, nspd;
    bit run, tk, d;
    d    = dr & DIR_EN;
    n    = period_of(m_speed, m_slow);
    run  = (m_state == 1) && !sp && !pa;
    tk   = run && !m_pending && (m_age == n - 1);
    m_tick = tk;
    m_wrap = tk && (d ? (m_count == 0) : (m_count == CMAX));
    if (sp || m_pending) m_age = 0;
    else if (run) m_age = tk ? 0 : m_age + 1;
    if (sp) m_count = 0;
    else if (tk) m_count = d ? (m_count + CMAX) % (CMAX + 1) : (m_count + 1) % (CMAX + 1);
    if (sp) m_state = 0;
    else if (pa) begin
      if (m_state == 1) m_state = 2;
    end else if (st) m_state = 1;
    nspd = m_speed;
    if (up && !dn) nspd = (m_speed < MS) ? m_speed + 1 : MS;
    else if (dn && !up) nspd = (m_speed > 1) ? m_speed - 1 : 1;
    m_pending = (nspd != m_speed) || (sl != m_slow);
    m_speed = nspd;
    m_slow  = sl;
  endtask

  task automatic step(input bit st, pa, sp, up, dn);
    intf.i_start    = st;
    intf.i_pause    = pa;
    intf.i_stop     = sp;
    intf.i_speed_up = up;
    intf.i_speed_dn = dn;
    intf.i_slow     = cur_slow;
`ifdef COUNT_DOWN_EN
    intf.i_dir      = cur_dir;
`endif
    @(posedge clk);
    model_edge(st, pa, sp, up, dn, cur_slow, cur_dir);
    cyc++;
    #1;
    check("model_count", intf.o_count, m_count);
    check("model_tick",  intf.o_tick,  m_tick);
    check("model_wrap",  intf.o_wrap,  m_wrap);
    check("model_speed", intf.o_speed, m_speed);
    check("model_state", intf.o_state, m_state);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic collect(input int n);
    tq.delete();
    qc.delete();
    repeat (n) begin
      idle(1);
      if (intf.o_tick === 1'b1) begin
        tq.push_back(cyc);
        qc.push_back(int'(intf.o_count));
      end
    end
  endtask

  function automatic int qget(input int idx);
    return (idx < tq.size()) ? tq[idx] : -1;
  endfunction

  // Reset is held with commands active to show it overrides them.
  task automatic do_reset();
    rst = 1'b1;
    cur_slow = 1'b0; cur_dir = 1'b0;
    intf.i_start = 1'b1; intf.i_pause = 1'b0; intf.i_stop = 1'b0;
    intf.i_speed_up = 1'b1; intf.i_speed_dn = 1'b0; intf.i_slow = 1'b0;
`ifdef COUNT_DOWN_EN
    intf.i_dir = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cyc = 0;
    check("rst_count", intf.o_count, 0);
    check("rst_tick",  intf.o_tick,  0);
    check("rst_wrap",  intf.o_wrap,  0);
    check("rst_speed", intf.o_speed, 1);
    check("rst_state", intf.o_state, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, p, s;

    // Basic run: start in cycle 0, ticks at 9/17/25
    do_reset();
    cyc = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("state_after_start", intf.o_state, 1);
    check("start_cycle", cyc, 1);
    collect(25);
    check("basic_tick_cnt", tq.size(), 3);
    check("basic_tick0", qget(0), 9);
    check("basic_tick1", qget(1), 17);
    check("basic_tick2", qget(2), 25);
    for (int i = 0; i < 3; i++)
      check("basic_count", (i < qc.size()) ? qc[i] : -1, i + 1);

    // Speed 4 -> period 2
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("stop_clears_count", intf.o_count, 0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    check("speed4", intf.o_speed, 4);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    r = cyc;
    collect(10);
    check("spd4_tick_cnt", tq.size(), 5);
    for (int i = 0; i < 5; i++) check("spd4_tick_at", qget(i), r + 2 * (i + 1));

    // Saturation at both ends and simultaneous up+dn
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("speed_sat_hi", intf.o_speed, 8);
    idle(1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    r = cyc;
    collect(6);
    check("spd8_tick_cnt", tq.size(), 6);
    check("spd8_first", qget(0), r + 1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("speed_sat_lo", intf.o_speed, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("speed_updn", intf.o_speed, 2);

    // Slow mode at speed 2, then a mid-period speed change
    cur_slow = 1'b1;
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    r = cyc;
    collect(40);
    check("slow_tick_cnt", tq.size(), 2);
    check("slow_tick0", qget(0), r + 16);
    check("slow_tick1", qget(1), r + 32);
    p = cyc;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    collect(30);
    check("restart_tick", qget(0), p + 2 + 24);

    // Wrap after 16 ticks at period 1
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cur_slow = 1'b0;
    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      idle(1);
      check("wrap_tick",  intf.o_tick, 1);
      check("wrap_count", intf.o_count, k % 16);
      check("wrap_flag",  intf.o_wrap, (k == 16) ? 1 : 0);
    end
`ifdef COUNT_DOWN_EN
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cur_dir = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    check("down_count", intf.o_count, 15);
    check("down_wrap",  intf.o_wrap, 1);
    idle(1);
    check("down_count2", intf.o_count, 14);
    check("down_wrap2",  intf.o_wrap, 0);
    cur_dir = 1'b0;
`endif

    // Pause at divider 5 for 20 cycles, resume, combined stop
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    r = cyc;
    idle(5);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("paused_state", intf.o_state, 2);
    collect(19);
    check("pause_no_tick", tq.size(), 0);
    s = cyc;
    check("pause_len", s - r, 25);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    collect(5);
    check("resume_tick", qget(0), s + 4);
    check("resume_count", (qc.size() > 0) ? qc[0] : -1, 1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("combo_state", intf.o_state, 0);
    check("combo_count", intf.o_count, 0);

    // Table-driven command vectors from reset
    vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 2};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 2};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1};
    vt[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1};
    vt[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1};
    vt[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1};
    vt[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1};
    vt[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 2};
    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(vt[i].st, vt[i].pa, vt[i].sp, vt[i].up, vt[i].dn);
      check("vec_state", intf.o_state, vt[i].exp_state);
      check("vec_speed", intf.o_speed, vt[i].exp_speed);
    end

    // Randomised traffic against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit st, pa, sp, up, dn;
      st = ($urandom_range(0, 99) < 20);
      pa = ($urandom_range(0, 99) < 4);
      sp = ($urandom_range(0, 99) < 2);
      up = ($urandom_range(0, 99) < 5);
      dn = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 99) < 2) cur_slow = ~cur_slow;
      if ($urandom_range(0, 99) < 10) cur_dir = ~cur_dir;
      step(st, pa, sp, up, dn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
